// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// FSM state encoding and default counter width.
package clk_meter_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an async input plus edge detect.
// rise/fall are single-cycle strobes in the clk domain.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] syncQ;
  logic              prevQ;

  // shift the async input through the synchronizer, then the compare flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncQ <= '0;
      prevQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[STAGES-2:0], d};
      prevQ <= syncQ[STAGES-1];
    end
  end

  // edges from the last synchronized sample vs. its delayed copy
  always_comb begin
    rise = syncQ[STAGES-1] & ~prevQ;
    fall = ~syncQ[STAGES-1] & prevQ;
  end

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock in clk cycles,
// tracks frequency lock against a target and flags a stalled input.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic [CNT_W-1:0] expected_period,
  input  logic [CNT_W-1:0] tolerance,
  input  logic             clear_err,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             locked,
  output logic             timeout
);

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] highQ;
  logic [LW-1:0]    lockCnt;
  logic [LW-1:0]    lockNxt;
  logic [CNT_W:0]   diff;
  logic             inTol;
  logic             rise;
  logic             fall;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (clk_in),
    .rise (rise),
    .fall (fall)
  );

  // absolute deviation of the period just finished, one extra bit so it never wraps
  always_comb begin
    diff = '0;
    if (cnt >= expected_period)
      diff = {1'b0, cnt} - {1'b0, expected_period};
    else
      diff = {1'b0, expected_period} - {1'b0, cnt};
    inTol = (diff <= {1'b0, tolerance});
    lockNxt = (lockCnt == LOCK_MAX) ? LOCK_MAX : lockCnt + LW'(1);
  end

  // measurement FSM, counters, lock tracking and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      highQ      <= '0;
      lockCnt    <= '0;
      meas_valid <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (clear_err)
        timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period     <= cnt;
            high_time  <= highQ;
            meas_valid <= 1'b1;
            cnt        <= CNT_ONE;
            if (inTol) begin
              lockCnt <= lockNxt;
              locked  <= (lockNxt == LOCK_MAX);
            end else begin
              lockCnt <= '0;
              locked  <= 1'b0;
            end
          end else begin
            if (fall)
              highQ <= cnt;
            if (cnt == CNT_MAX - CNT_ONE) begin
              // stalled input: saturate and flag; overrides clear_err
              cnt     <= CNT_MAX;
              state   <= TIMEOUT;
              timeout <= 1'b1;
              locked  <= 1'b0;
              lockCnt <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        TIMEOUT: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: segment-level model of the
// slow clock predicts every measurement, monitor checks meas_valid.
module tb_clk_period_meter;

  localparam int CW = 8;
  localparam int LC = 4;
  localparam int TMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_in = 1'b0;
  logic clear_err = 1'b0;
  logic [CW-1:0] expected_period = 8'd10;
  logic [CW-1:0] tolerance = 8'd0;
  logic meas_valid;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic locked;
  logic timeout;

  clk_period_meter #(
    .CNT_W(CW),
    .SYNC_STAGES(2),
    .LOCK_COUNT(LC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_in         (clk_in),
    .expected_period(expected_period),
    .tolerance      (tolerance),
    .clear_err      (clear_err),
    .meas_valid     (meas_valid),
    .period         (period),
    .high_time      (high_time),
    .locked         (locked),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    bit lk;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lastValid = 0;
  int toCycle = 0;
  bit toPrev = 1'b0;

  // reference model state: one segment = one slow-clock period
  bit armed = 1'b0;
  int segLen = 0;
  int segHigh = 0;
  int lc = 0;
  bit lk = 1'b0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: pop expected measurement on every meas_valid
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (timeout && !toPrev) toCycle = cyc;
    toPrev = timeout;
    if (meas_valid) begin
      lastValid = cyc;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL meas_unexpected: period=%0d high=%0d", period, high_time);
      end else begin
        e = q.pop_front();
        if (period != e.p || high_time != e.h || locked != e.lk) begin
          errors++;
          $display("FAIL meas: got p=%0d h=%0d lk=%0d required p=%0d h=%0d lk=%0d",
                   period, high_time, locked, e.p, e.h, e.lk);
        end
      end
    end
  end

  // a rising edge ends the current segment: predict its report
  task automatic rise_evt();
    exp_t e;
    int d;
    if (armed && segLen < TMAX) begin
      d = segLen - int'(expected_period);
      if (d < 0) d = -d;
      if (d <= int'(tolerance)) begin
        lc = (lc < LC) ? lc + 1 : LC;
        lk = (lc == LC);
      end else begin
        lc = 0;
        lk = 1'b0;
      end
      e.p = segLen;
      e.h = segHigh;
      e.lk = lk;
      q.push_back(e);
    end else if (armed) begin
      lc = 0;
      lk = 1'b0;
    end
    armed = 1'b1;
  endtask

  // drive one slow-clock period: high h cycles, low p-h cycles
  task automatic seg(int p, int h);
    clk_in = 1'b1;
    rise_evt();
    segLen = p;
    segHigh = h;
    repeat (h) @(negedge clk);
    clk_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, int'(meas_valid), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_high"}, int'(high_time), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    int p;
    int h;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // divide-by-10 reference, tolerance 0
    repeat (6) seg(10, 5);

    // off-frequency while locked, then recover
    tolerance = 8'd1;
    seg(12, 6);
    seg(12, 6);
    repeat (5) seg(10, 5);

    // in-tolerance jitter, then one outlier
    seg(11, 5);
    seg(9, 4);
    seg(11, 6);
    seg(10, 5);
    seg(8, 4);
    repeat (3) seg(10, 5);

    // randomized periods around a new target
    expected_period = 8'd20;
    tolerance = 8'd3;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        p = 16 + int'($urandom_range(0, 8));
      else
        p = int'($urandom_range(2, 40));
      h = int'($urandom_range(1, p - 1));
      seg(p, h);
    end

    // fastest measurable input
    repeat (8) seg(2, 1);

    // stalled input: timeout
    seg(300, 5);
    chk("to_set", int'(timeout), 1);
    chk("to_locked", int'(locked), 0);
    chk("to_timing", toCycle - lastValid, TMAX - 1);
    repeat (3) seg(10, 5);
    chk("to_sticky", int'(timeout), 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
    segLen += 2;
    chk("to_clear", int'(timeout), 0);

    // reset mid-period while locked
    expected_period = 8'd10;
    tolerance = 8'd0;
    repeat (6) seg(10, 5);
    clk_in = 1'b1;
    rise_evt();
    repeat (5) @(negedge clk);
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_locked", int'(locked), 1);
    chk("pre_rst_queue", q.size(), 0);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    armed = 1'b0;
    lc = 0;
    lk = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    repeat (6) seg(10, 5);

    // final edge closes the last period, then drain
    clk_in = 1'b1;
    rise_evt();
    repeat (12) @(negedge clk);
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
